kcpsm3_irq_ctrl: RTL and testbench

- Four-source interrupt controller for the KCPSM3 (PicoBlaze) processor.
- Takes four active-low request lines, the same polarity convention as the inverted-input OR gate cells, and synchronises them and latches falling edges as pending.
- Arbitrates among pending, unmasked sources and drives the processor's single interrupt input.
- The processor identifies the winning source and retires it through a small port-mapped register set.

---
 rtl/kcpsm3_irq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_kcpsm3_irq_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kcpsm3_irq_ctrl.sv
// kcpsm3_irq_ctrl
//   Four-source interrupt controller for a KCPSM3 (PicoBlaze) core.
//   Active-low request lines are synchronised and their falling edges are
//   latched as pending. Pending, unmasked sources are arbitrated (fixed
//   priority or round-robin) onto the single interrupt line. The core
//   acknowledges, reads the serviced id, and retires it with an EOI write.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   irq_n[3:0]     active-low requests, asynchronous to clk
//   interrupt      to KCPSM3 interrupt input
//   interrupt_ack  from KCPSM3, single-cycle pulse
//   port_id[7:0]   KCPSM3 port address
//   write_strobe   KCPSM3 write strobe
//   out_port[7:0]  KCPSM3 write data
//   read_data[7:0] registered read data for the KCPSM3 in_port mux
//
// Register map (offset from BASE_ADDR)
//   +0  R: {active, 0, svc_id[1:0], pending[3:0]}   W: W1C pending[3:0]
//   +1  R/W: mask[3:0] (1 = enabled)
//   +2  R: {6'b0, svc_id}
//   +3  W: end-of-interrupt, data ignored; reads 0
//
// State    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no interrupt outstanding; arbitrate when pending & mask != 0
// S_REQ    | interrupt asserted for the latched grant; waiting for ack
// S_SERVICE| grant retired from pending; handler running, waiting for EOI

module kcpsm3_irq_ctrl #(
  parameter logic [7:0] BASE_ADDR = 8'hE0,
  parameter int         RR_MODE   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] irq_n,
  output logic       interrupt,
  input  logic       interrupt_ack,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] read_data
);

  localparam logic [7:0] ADDR_STAT = BASE_ADDR;
  localparam logic [7:0] ADDR_MASK = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_SVC  = BASE_ADDR + 8'd2;
  localparam logic [7:0] ADDR_EOI  = BASE_ADDR + 8'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] sync1, sync2, dly;
  logic [2:0] arm;
  logic [3:0] fall;
  logic [3:0] pending;
  logic [3:0] mask;
  logic [3:0] eligible;
  logic [3:0] clr;
  logic [1:0] grant;
  logic [1:0] svc_id;
  logic [1:0] rr_ptr;
  logic [1:0] winner;
  logic       active;
  logic       wr_stat, wr_mask, wr_eoi;
  logic       ack_take;
  logic [7:0] rd_next;
  logic       unused_hi;

  assign unused_hi = ^out_port[7:4];

  // Synchroniser, delay flop and a reset-release arming chain. The preset
  // to 1 keeps the pipe quiet during reset, but a line still held low after
  // release would walk a 1->0 transition through it; arm suppresses edge
  // detection until the pipe holds only real post-reset samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      dly   <= 4'hF;
      arm   <= 3'b000;
    end else begin
      sync1 <= irq_n;
      sync2 <= sync1;
      dly   <= sync2;
      arm   <= {arm[1:0], 1'b1};
    end
  end

  assign fall = arm[2] ? (dly & ~sync2) : 4'b0000;

  assign wr_stat  = write_strobe && (port_id == ADDR_STAT);
  assign wr_mask  = write_strobe && (port_id == ADDR_MASK);
  assign wr_eoi   = write_strobe && (port_id == ADDR_EOI);
  assign ack_take = (state == S_REQ) && interrupt_ack;
  assign active   = (state != S_IDLE);

  assign clr = (wr_stat  ? out_port[3:0]        : 4'b0000) |
               (ack_take ? (4'b0001 << grant)   : 4'b0000);

  // A fresh edge wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 4'h0;
      mask    <= 4'h0;
    end else begin
      pending <= (pending & ~clr) | fall;
      if (wr_mask) mask <= out_port[3:0];
    end
  end

  assign eligible = pending & mask;

  // First set bit scanning upward from ptr with wrap; ptr=0 gives fixed
  // priority with source 0 highest.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign winner = pick(eligible, (RR_MODE != 0) ? rr_ptr : 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      grant     <= 2'd0;
      svc_id    <= 2'd0;
      rr_ptr    <= 2'd0;
      interrupt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|eligible) begin
            grant     <= winner;
            interrupt <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // grant stays frozen here even if its source is masked or cleared
          if (interrupt_ack) begin
            svc_id    <= grant;
            interrupt <= 1'b0;
            state     <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (wr_eoi) begin
            if (RR_MODE != 0) rr_ptr <= svc_id + 2'd1;
            // svc_id only carries meaning while a source is being serviced
            svc_id <= 2'd0;
            state  <= S_IDLE;
          end
        end
        default: begin
          interrupt <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_next = 8'h00;
    if (port_id == ADDR_STAT)      rd_next = {active, 1'b0, svc_id, pending};
    else if (port_id == ADDR_MASK) rd_next = {4'b0000, mask};
    else if (port_id == ADDR_SVC)  rd_next = {6'b000000, svc_id};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) read_data <= 8'h00;
    else          read_data <= rd_next;
  end

endmodule

// File: tb/tb_kcpsm3_irq_ctrl.sv
// tb_kcpsm3_irq_ctrl
//   Two instances: inst 0 fixed priority, inst 1 round-robin. A driver
//   process plays the KCPSM3 role and pushes expected read_data/interrupt
//   values, tagged with the cycle they must appear on, into a scoreboard
//   queue; a monitor pops and compares them at the matching negedge.

module tb_kcpsm3_irq_ctrl;

  localparam logic [7:0] BASE = 8'hE0;

  logic            clk;
  logic            reset_n;
  logic [1:0][3:0] irq_n_v;
  logic [1:0]      ack_v;
  logic [1:0][7:0] pid_v;
  logic [1:0]      ws_v;
  logic [1:0][7:0] op_v;
  logic            int_f, int_r;
  logic [7:0]      rd_f, rd_r;

  kcpsm3_irq_ctrl #(.BASE_ADDR(BASE), .RR_MODE(0)) u_fix (
    .clk(clk), .reset_n(reset_n), .irq_n(irq_n_v[0]), .interrupt(int_f),
    .interrupt_ack(ack_v[0]), .port_id(pid_v[0]), .write_strobe(ws_v[0]),
    .out_port(op_v[0]), .read_data(rd_f)
  );

  kcpsm3_irq_ctrl #(.BASE_ADDR(BASE), .RR_MODE(1)) u_rr (
    .clk(clk), .reset_n(reset_n), .irq_n(irq_n_v[1]), .interrupt(int_r),
    .interrupt_ack(ack_v[1]), .port_id(pid_v[1]), .write_strobe(ws_v[1]),
    .out_port(op_v[1]), .read_data(rd_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int         cyc;
    bit         is_rd;
    int         inst;
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cur   = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_of(input int i);
    return (i == 0) ? rd_f : rd_r;
  endfunction

  function automatic logic int_of(input int i);
    return (i == 0) ? int_f : int_r;
  endfunction

  // monitor
  always @(negedge clk) begin
    chk_t e;
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      e = sb.pop_front();
      if (e.cyc != cycle) begin
        n_chk++;
        n_err++;
        $display("FAIL %s: checked late at cycle %0d, required %0d", e.name, cycle, e.cyc);
      end else if (e.is_rd) begin
        check(e.name, rd_of(e.inst), e.exp);
      end else begin
        check(e.name, {7'b0, int_of(e.inst)}, e.exp);
      end
    end
  end

  // ---------------- reference model (current instance) ----------------
  logic [3:0] m_pend, m_mask;
  logic [1:0] m_grant, m_svc;
  bit         m_req, m_active, m_rr;
  int         m_ptr;

  task automatic m_reset();
    m_pend = 4'h0; m_mask = 4'h0; m_grant = 2'd0; m_svc = 2'd0;
    m_req = 1'b0; m_active = 1'b0; m_ptr = 0;
  endtask

  function automatic int m_arb();
    int start;
    start = m_rr ? m_ptr : 0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (m_pend[i] && m_mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_step();
    int w;
    w = m_arb();
    if (!m_req && !m_active && w >= 0) begin
      m_req   = 1'b1;
      m_grant = 2'(w);
    end
  endtask

  function automatic logic [7:0] m_stat();
    return {(m_active | m_req), 1'b0, m_svc, m_pend};
  endfunction

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd_push(input int off, input logic [7:0] exp, input string nm);
    chk_t t;
    pid_v[cur] = 8'(BASE + 8'(off));
    t.cyc = cycle + 1; t.is_rd = 1'b1; t.inst = cur; t.exp = exp; t.name = nm;
    sb.push_back(t);
  endtask

  task automatic irq_push(input bit exp, input string nm);
    chk_t t;
    t.cyc = cycle + 1; t.is_rd = 1'b0; t.inst = cur; t.exp = {7'b0, exp}; t.name = nm;
    sb.push_back(t);
  endtask

  task automatic rd_chk(input int off, input logic [7:0] exp, input string nm);
    rd_push(off, exp, nm);
    tick();
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    pid_v[cur] = 8'(BASE + 8'(off));
    op_v[cur]  = d;
    ws_v[cur]  = 1'b1;
    tick();
    ws_v[cur]  = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] bits, input int hold);
    irq_n_v[cur] = irq_n_v[cur] & ~bits;
    repeat (hold) tick();
    irq_n_v[cur] = irq_n_v[cur] | bits;
    repeat (4) tick();
    m_pend = m_pend | bits;
    m_step();
  endtask

  task automatic set_mask(input logic [3:0] m);
    wr(1, {4'h0, m});
    m_mask = m;
    m_step();
  endtask

  // want >= 0 gives a hand-derived expected id; -1 uses the model
  task automatic service_take(input int want);
    irq_push(1'b1, "irq_before_ack");
    tick();
    ack_v[cur] = 1'b1;
    irq_push(1'b0, "irq_after_ack");
    tick();
    ack_v[cur] = 1'b0;
    m_pend   = m_pend & ~(4'b0001 << m_grant);
    m_svc    = m_grant;
    m_active = 1'b1;
    m_req    = 1'b0;
    rd_chk(2, (want >= 0) ? 8'(want) : {6'b0, m_svc}, "svc_id");
  endtask

  task automatic eoi();
    irq_push(1'b0, "irq_at_eoi");
    wr(3, 8'(($urandom)));
    if (m_rr) m_ptr = (m_svc + 1) % 4;
    m_svc    = 2'd0;
    m_active = 1'b0;
    m_step();
    irq_push(m_req, "irq_after_eoi");
    tick();
  endtask

  task automatic rand_phase(input int iters);
    logic [7:0] d;
    int guard;
    for (int it = 0; it < iters; it++) begin
      if ($urandom_range(0, 2) == 0) set_mask(4'($urandom_range(0, 15)));
      pulse(4'($urandom_range(1, 15)), $urandom_range(1, 5));
      guard = 0;
      while (m_req && guard < 40) begin
        service_take(-1);
        case ($urandom_range(0, 3))
          0: pulse(4'($urandom_range(1, 15)), $urandom_range(1, 3));
          1: begin
            d = 8'($urandom);
            wr(0, d);
            m_pend = m_pend & ~d[3:0];
          end
          2: begin
            ack_v[cur] = 1'b1;
            tick();
            ack_v[cur] = 1'b0;
          end
          default: tick();
        endcase
        rd_chk(0, m_stat(), "rand_status");
        eoi();
        guard++;
      end
      check("drain_bound", {7'b0, m_req}, 8'h00);
      rd_chk(1, {4'h0, m_mask}, "rand_mask");
      rd_chk(0, m_stat(), "rand_idle_status");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    irq_n_v = '1;
    ack_v   = '0;
    pid_v   = '0;
    ws_v    = '0;
    op_v    = '0;
    m_rr    = 1'b0;
    m_reset();
    #3 reset_n = 1'b0;
    #1;
    check("rst_int_fix", {7'b0, int_f}, 8'h00);
    check("rst_rd_fix", rd_f, 8'h00);
    check("rst_int_rr", {7'b0, int_r}, 8'h00);
    check("rst_rd_rr", rd_r, 8'h00);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();

    // ---- fixed instance ----
    cur = 0; m_rr = 1'b0;
    rd_chk(0, 8'h00, "rst_status");
    rd_chk(1, 8'h00, "rst_mask");
    set_mask(4'hF);

    // source 2 held low for 1 us; check latency edge by edge
    irq_n_v[0][2] = 1'b0;
    tick();
    tick();
    rd_push(0, 8'h00, "t1_pend_early"); irq_push(1'b0, "t1_irq_early"); tick();
    rd_push(0, 8'h04, "t1_pend_set");   irq_push(1'b1, "t1_irq_rise");  tick();
    repeat (96) tick();
    irq_n_v[0][2] = 1'b1;
    repeat (4) tick();
    m_pend = 4'h4;
    m_step();
    service_take(2);
    rd_chk(0, 8'hA0, "t1_status_service");
    eoi();
    rd_chk(0, 8'h00, "t1_status_after_eoi");

    // sources 3 and 1 together: 1 first, then 3
    pulse(4'b1010, 2);
    service_take(1);
    rd_chk(0, 8'h98, "fix_status_svc1");
    eoi();
    service_take(3);
    eoi();

    // masked request, stray ack and stray EOI, then unmask
    set_mask(4'h0);
    pulse(4'b0001, 2);
    irq_push(1'b0, "masked_irq_low");
    rd_chk(0, 8'h01, "masked_pending");
    ack_v[0] = 1'b1; tick(); ack_v[0] = 1'b0;
    rd_chk(0, 8'h01, "stray_ack_ignored");
    wr(3, 8'h00);
    irq_push(1'b0, "stray_eoi_irq");
    rd_chk(0, 8'h01, "stray_eoi_ignored");
    wr(1, 8'h01);
    m_mask = 4'h1;
    m_step();
    irq_push(1'b1, "irq_after_unmask");
    tick();
    service_take(0);
    pulse(4'b0001, 1);
    rd_chk(0, 8'h81, "service_new_pending");
    wr(0, 8'hF1);
    m_pend = 4'h0;
    rd_chk(0, 8'h80, "w1c_in_service");
    eoi();

    // new edge on source 1 landing on its own ack cycle
    set_mask(4'h2);
    pulse(4'b0010, 3);
    irq_push(1'b1, "col_irq_up");
    irq_n_v[0][1] = 1'b0;
    tick();
    tick();
    ack_v[0] = 1'b1;
    irq_push(1'b0, "col_irq_ack");
    tick();
    ack_v[0] = 1'b0;
    repeat (2) tick();
    irq_n_v[0][1] = 1'b1;
    repeat (4) tick();
    m_svc = 2'd1; m_active = 1'b1; m_req = 1'b0; m_pend = 4'h2;
    rd_chk(0, 8'h92, "col_pending_kept");
    eoi();
    service_take(1);
    eoi();

    rand_phase(25);

    // ---- round-robin instance ----
    cur = 1; m_rr = 1'b1;
    m_reset();
    set_mask(4'hF);
    pulse(4'hF, 2);
    for (int id = 0; id < 4; id++) begin
      service_take(id);
      eoi();
    end
    pulse(4'b0011, 2);
    service_take(0);
    eoi();
    service_take(1);
    eoi();
    rand_phase(25);

    // ---- reset while in REQ, line held low across release ----
    cur = 0; m_rr = 1'b0;
    set_mask(4'hF);
    pulse(4'b0100, 1);
    irq_push(1'b1, "pre_rst_irq");
    tick();
    #2 reset_n = 1'b0;
    irq_n_v[0][3] = 1'b0;
    #1;
    check("async_rst_int", {7'b0, int_f}, 8'h00);
    check("async_rst_rd", rd_f, 8'h00);
    tick();
    tick();
    reset_n = 1'b1;
    m_reset();
    repeat (8) tick();
    irq_push(1'b0, "post_rst_irq");
    rd_chk(0, 8'h00, "post_rst_no_pending");
    rd_chk(1, 8'h00, "post_rst_mask");
    irq_n_v[0][3] = 1'b1;
    repeat (4) tick();

    repeat (2) tick();
    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
